// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the receiver and transmitter blocks.
package i2s_pkg;

  localparam int   I2S_BITSIZE = 16;
  localparam logic CH_LEFT     = 1'b0;
  localparam logic CH_RIGHT    = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin.
// It also produces registered single-cycle rise and fall pulses.
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain  <= '0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
      chain  <= {chain[STAGES-2:0], din};
      sync_d <= chain[STAGES-1];
      rise   <= chain[STAGES-1] & ~sync_d;
      fall   <= ~chain[STAGES-1] & sync_d;
    end
  end

  assign sync = chain[STAGES-1];

endmodule

// File: rtl/i2s_rx_sync.sv
// I2S receiver: oversamples the codec pins on the system clock and
// delivers left-justified signed samples with one-cycle valid strobes.
module i2s_rx_sync
  import i2s_pkg::*;
#(
  parameter int BITSIZE     = I2S_BITSIZE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bclk,
  input  logic                      lrclk,
  input  logic                      sdata,
  output logic signed [BITSIZE-1:0] left_chan,
  output logic signed [BITSIZE-1:0] right_chan,
  output logic                      valid_l,
  output logic                      valid_r,
  output logic                      short_word
);

  localparam int              CNT_W    = $clog2(BITSIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITSIZE);

  logic bclk_level_unused, bclk_rise, bclk_fall_unused;
  logic lr_sync, lr_rise_unused, lr_fall_unused;
  logic sd_sync, sd_rise_unused, sd_fall_unused;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk  (clk),
    .rst  (rst),
    .din  (bclk),
    .sync (bclk_level_unused),
    .rise (bclk_rise),
    .fall (bclk_fall_unused)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lr (
    .clk  (clk),
    .rst  (rst),
    .din  (lrclk),
    .sync (lr_sync),
    .rise (lr_rise_unused),
    .fall (lr_fall_unused)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
    .clk  (clk),
    .rst  (rst),
    .din  (sdata),
    .sync (sd_sync),
    .rise (sd_rise_unused),
    .fall (sd_fall_unused)
  );

  logic [BITSIZE-1:0] shift_reg;
  logic [BITSIZE-1:0] shift_step;
  logic [BITSIZE-1:0] word;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   cnt_step;
  logic               lr_prev;
  logic               armed;

  // Shift state after taking the current bit, and that word left-justified.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch appears.
    shift_step = shift_reg;
    cnt_step   = bit_cnt;
    if (bit_cnt < CNT_FULL) begin
      shift_step = {shift_reg[BITSIZE-2:0], sd_sync};
      cnt_step   = bit_cnt + CNT_W'(1);
    end
    word = shift_step << (CNT_FULL - cnt_step);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      lr_prev    <= 1'b0;
      armed      <= 1'b0;
      left_chan  <= '0;
      right_chan <= '0;
      valid_l    <= 1'b0;
      valid_r    <= 1'b0;
      short_word <= 1'b0;
    end else begin
      valid_l    <= 1'b0;
      valid_r    <= 1'b0;
      short_word <= 1'b0;
      if (bclk_rise) begin
        shift_reg <= shift_step;
        bit_cnt   <= cnt_step;
        // The bit taken on a word-select change still belongs to the old slot.
        if (lr_sync != lr_prev) begin
          if (armed) begin
            if (lr_prev == CH_LEFT) begin
              left_chan <= $signed(word);
              valid_l   <= 1'b1;
            end else begin
              right_chan <= $signed(word);
              valid_r    <= 1'b1;
            end
            short_word <= (cnt_step < CNT_FULL);
          end
          shift_reg <= '0;
          bit_cnt   <= '0;
          armed     <= 1'b1;
          lr_prev   <= lr_sync;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_sync.sv
// Bench for i2s_rx_sync: slot-level model of the I2S stream plus
// directed frames, checked on every cycle and against literal values.
module tb_i2s_rx_sync;

  localparam int BITSIZE     = 16;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 2;
  localparam int HALF        = 8;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        bclk  = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;
  logic [15:0] left_chan;
  logic [15:0] right_chan;
  logic        valid_l;
  logic        valid_r;
  logic        short_word;

  i2s_rx_sync #(.BITSIZE(BITSIZE), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .valid_l    (valid_l),
    .valid_r    (valid_r),
    .short_word (short_word)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int last_rise_cyc = 0;
  int last_lat      = -1;
  int n_vl = 0, n_vr = 0, n_sw = 0;
  logic [15:0] seen_l = '0, seen_r = '0;
  logic [15:0] sw_vals[$];
  bit chk_en = 1'b0;

  typedef struct {
    int          due;
    logic        ch;
    logic [15:0] word;
    logic        sw;
  } ev_t;

  ev_t         ev_q[$];
  logic [15:0] exp_l = '0, exp_r = '0;
  logic        exp_vl = 1'b0, exp_vr = 1'b0, exp_sw = 1'b0;

  logic        m_bits[$];
  bit          m_armed = 1'b0;
  logic        m_prev  = 1'b0;
  logic [15:0] m_last_l = '0, m_last_r = '0;

  logic dq[$];
  logic cq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_armed = 1'b0;
    m_prev  = 1'b0;
  endtask

  // Slot-level model: collect the bits of a slot, close it on a word-select change.
  task automatic model_rise(input logic lr, input logic d);
    logic [15:0] w;
    m_bits.push_back(d);
    if (lr !== m_prev) begin
      if (m_armed) begin
        w = '0;
        for (int i = 0; i < m_bits.size() && i < BITSIZE; i++) w[BITSIZE-1-i] = m_bits[i];
        ev_q.push_back('{due: cyc + LAT, ch: m_prev, word: w, sw: (m_bits.size() < BITSIZE)});
        if (m_prev) m_last_r = w;
        else        m_last_l = w;
      end
      m_bits.delete();
      m_armed = 1'b1;
      m_prev  = lr;
    end
  endtask

  task automatic add_slot(input logic ch, input logic [15:0] word, input int nbits, input int len);
    for (int j = 0; j < len; j++) begin
      dq.push_back((j < nbits) ? word[15-j] : 1'b0);
      cq.push_back(ch);
    end
  endtask

  task automatic add_frames(input int n, input logic [15:0] lw, input logic [15:0] rw, input int len);
    for (int k = 0; k < n; k++) begin
      add_slot(1'b0, lw, 16, len);
      add_slot(1'b1, rw, 16, len);
    end
    add_slot(1'b0, 16'h0000, 0, 1);
  endtask

  // One BCLK period = 16 clk, low half first; word select leads data by one bit.
  task automatic play(input int skew, input int rst_at);
    int   n;
    int   idx;
    logic lr;
    n = dq.size();
    for (int c = 0; c < 16 * n; c++) begin
      @(posedge clk);
      #1;
      idx = (c - skew + 32) / 16 - 2;
      if (idx < 0) idx = 0;
      if (idx > n - 1) idx = n - 1;
      lr = (idx + 1 < n) ? cq[idx+1] : cq[idx];
      bclk  = ((c % 16) >= HALF);
      lrclk = lr;
      sdata = dq[idx];
      rst   = (c == rst_at);
      if (c == rst_at) model_reset();
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("midrst_left", 32'(left_chan), 32'h0);
        check("midrst_right", 32'(right_chan), 32'h0);
      end
      if ((c % 16) == HALF) begin
        last_rise_cyc = cyc;
        model_rise(lr, dq[idx]);
      end
    end
    dq.delete();
    cq.delete();
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    bclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic start_test();
    n_vl = 0;
    n_vr = 0;
    n_sw = 0;
    sw_vals.delete();
  endtask

  task automatic drain();
    repeat (LAT + 4) @(posedge clk);
    #1;
  endtask

  // Expected-output timeline, advanced at each active edge.
  initial forever begin
    @(posedge clk);
    cyc    = cyc + 1;
    exp_vl = 1'b0;
    exp_vr = 1'b0;
    exp_sw = 1'b0;
    if (rst) begin
      exp_l = '0;
      exp_r = '0;
      ev_q.delete();
    end else if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
      ev_t e;
      e = ev_q.pop_front();
      if (e.ch) begin
        exp_r  = e.word;
        exp_vr = 1'b1;
      end else begin
        exp_l  = e.word;
        exp_vl = 1'b1;
      end
      exp_sw = e.sw;
    end
  end

  // Per-cycle comparison on the opposite edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("valid_l", 32'(valid_l), 32'(exp_vl));
      check("valid_r", 32'(valid_r), 32'(exp_vr));
      check("short_word", 32'(short_word), 32'(exp_sw));
      check("left_chan", 32'(left_chan), 32'(exp_l));
      check("right_chan", 32'(right_chan), 32'(exp_r));
      if (valid_l === 1'b1) begin
        n_vl++;
        seen_l   = left_chan;
        last_lat = cyc - last_rise_cyc;
      end
      if (valid_r === 1'b1) begin
        n_vr++;
        seen_r   = right_chan;
        last_lat = cyc - last_rise_cyc;
      end
      if (short_word === 1'b1) begin
        n_sw++;
        sw_vals.push_back(valid_l ? left_chan : right_chan);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_left", 32'(left_chan), 32'h0);
    check("reset_right", 32'(right_chan), 32'h0);
    check("reset_valid_l", 32'(valid_l), 32'h0);
    check("reset_valid_r", 32'(valid_r), 32'h0);
    check("reset_short", 32'(short_word), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 64fs frames; the first boundary only arms.
    start_test();
    add_frames(3, 16'h8001, 16'h7FFE, 32);
    play(0, -1);
    drain();
    check("t1_count_l", 32'(n_vl), 32'd2);
    check("t1_count_r", 32'(n_vr), 32'd3);
    check("t1_count_short", 32'(n_sw), 32'd0);
    check("t1_left", 32'(seen_l), 32'h8001);
    check("t1_right", 32'(seen_r), 32'h7FFE);
    check("t1_model_left", 32'(m_last_l), 32'h8001);
    check("t1_model_right", 32'(m_last_r), 32'h7FFE);

    // 32fs: the LSB arrives together with the word-select change.
    reset_dut();
    start_test();
    add_frames(2, 16'hA5A5, 16'h5A5A, 16);
    play(0, -1);
    drain();
    check("t2_count_l", 32'(n_vl), 32'd1);
    check("t2_count_r", 32'(n_vr), 32'd2);
    check("t2_left", 32'(seen_l), 32'hA5A5);
    check("t2_right", 32'(seen_r), 32'h5A5A);
    check("t2_model_left", 32'(m_last_l), 32'hA5A5);

    // Truncated right slots: 10 bits, then a 1-bit glitch slot.
    reset_dut();
    start_test();
    add_slot(1'b0, 16'h8001, 16, 32);
    add_slot(1'b1, {10'b1011011101, 6'b000000}, 10, 10);
    add_slot(1'b0, 16'h8001, 16, 32);
    add_slot(1'b1, 16'h8000, 1, 1);
    add_slot(1'b0, 16'h8001, 16, 32);
    add_slot(1'b1, 16'h7FFE, 16, 32);
    add_slot(1'b0, 16'h0000, 0, 1);
    play(0, -1);
    drain();
    check("t3_count_l", 32'(n_vl), 32'd2);
    check("t3_count_r", 32'(n_vr), 32'd3);
    check("t3_count_short", 32'(n_sw), 32'd2);
    if (sw_vals.size() == 2) begin
      check("t3_short_word10", 32'(sw_vals[0]), 32'hB740);
      check("t3_short_word1", 32'(sw_vals[1]), 32'h8000);
    end
    check("t3_right", 32'(seen_r), 32'h7FFE);

    // Reset for one clk in the middle of a left slot (BCLK low).
    reset_dut();
    start_test();
    add_frames(3, 16'h1234, 16'hABCD, 32);
    play(0, 16 * 70 + 2);
    drain();
    check("t4_count_l", 32'(n_vl), 32'd1);
    check("t4_count_r", 32'(n_vr), 32'd3);
    check("t4_left", 32'(seen_l), 32'h1234);
    check("t4_right", 32'(seen_r), 32'hABCD);

    // Data and word-select skewed against the BCLK falling edge.
    for (int s = 0; s < 2; s++) begin
      reset_dut();
      start_test();
      add_frames(3, 16'h8001, 16'h7FFE, 32);
      play((s == 0) ? 2 : -2, -1);
      drain();
      check("t5_count_l", 32'(n_vl), 32'd2);
      check("t5_count_r", 32'(n_vr), 32'd3);
      check("t5_left", 32'(seen_l), 32'h8001);
      check("t5_right", 32'(seen_r), 32'h7FFE);
      check("t5_latency", 32'(last_lat), 32'd4);
    end

    // BCLK held static.
    start_test();
    repeat (1000) @(posedge clk);
    #1;
    check("t6_strobes", 32'(n_vl + n_vr + n_sw), 32'd0);
    check("t6_left", 32'(left_chan), 32'h8001);
    check("t6_right", 32'(right_chan), 32'h7FFE);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
